dsp48_mac_sched: RTL
====================

Name: dsp48_mac_sched

Overview:
- Sequences one DSP48E1 slice as a multiply-accumulate engine computing N-tap signed dot products.
- Accepts a command carrying the tap count, then streams (a, b) sample pairs.
- Drives the slice's data, OPMODE and clock-enable pins, including a pipeline tag shadow that aligns control with data.
- Returns a shifted, rounded and saturated result over a valid/ready handshake; sits between sample sources (FIR/correlator feeders) and the DSP primitive.

Parameters:
- LEN_W, 10, width of cmd_len; N taps = cmd_len+1 (1..2^LEN_W).
- OUT_W, 24, result width.
- OUT_SHIFT, 17, arithmetic right shift applied to P before saturation; 0..47.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- abort  in  1  soft flush; same effect as rst on block state, one cycle.
- cmd_valid  in  1  command handshake.
- cmd_ready  out  1  command handshake.
- cmd_len  in  LEN_W  tap count minus one.
- cmd_round  in  1  add 2^(OUT_SHIFT-1) rounding constant; ignored when OUT_SHIFT=0.
- in_valid  in  1  sample handshake.
- in_ready  out  1  sample handshake.
- in_a  in  25  signed multiplicand.
- in_b  in  18  signed multiplier.
- res_valid  out  1  result handshake.
- res_ready  in  1  result handshake.
- res_data  out  OUT_W  signed result.
- res_sat  out  1  res_data was clamped.
- dsp_a  out  30  in_a sign-extended.
- dsp_b  out  18  in_b.
- dsp_c  out  48  rounding constant.
- dsp_opmode  out  7  to slice OPMODE.
- dsp_cea2  out  1  slice A2 clock enable.
- dsp_ceb2  out  1  slice B2 clock enable.
- dsp_cem  out  1  slice M clock enable.
- dsp_cep  out  1  slice P clock enable.
- dsp_cectrl  out  1  slice control-register clock enable.
- dsp_rst  out  1  drives slice RSTA/RSTB/RSTM/RSTP/RSTCTRL.
- dsp_p  in  48  slice P output.

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high.
- Required slice configuration (fixed):
  - AREG=BREG=ACASCREG=BCASCREG=1, MREG=1, PREG=1, OPMODEREG=1.
  - CREG=0, ALUMODEREG=0, INMODEREG=0, USE_DPORT="FALSE".
  - ALUMODE=0, INMODE=0, CARRYINSEL=0, CARRYIN=0; these are tied in the wrapper, not driven here.
- Reset / abort values:
  - Controller: state IDLE, all tags cleared, res_valid=0, res_sat=0, res_data=0, cmd_ready=0 for the reset cycle, in_ready=0.
  - DSP pins: dsp_rst=1 for that cycle, all dsp_ce*=0, dsp_opmode=0.
- Global advance: en = !res_valid | res_ready.
  - When en=0, every dsp_ce* is 0 and in_ready=0, so the slice and tag pipeline freeze.
- FSM:
  - IDLE: cmd_ready=1. On the handshake, latch cnt=cmd_len and round, set first=1, go to RUN.
  - RUN: in_ready=en. Each sample accept marks the tag valid, first=first_flag and last=(cnt==0); cnt decrements and first clears. After the last accept, return to IDLE.
  - A back-to-back command is accepted the next cycle; no drain state is needed.
- Tag pipeline, three stages, advancing when en=1:
  - S1 (A2/B2 loaded), S2 (M loaded), S3 (P loaded).
  - dsp_cea2 = dsp_ceb2 = accept.
  - dsp_cem = en & S1.valid.
  - dsp_cectrl = en.
  - dsp_cep = en & S2.valid, so bubbles never accumulate.
- OPMODE, driven combinationally from S1 so OPMODE_reg aligns with M_reg:
  - S1.first → 7'b0110101 (X=M, Y=M, Z=C): starts a new sum with the rounding constant.
  - Otherwise → 7'b0100101 (Z=P).
- dsp_c = round ? 48'd1<<(OUT_SHIFT-1) : 0, latched per command and held until the next command's first tag reaches S1.
- Result:
  - When en & S3.valid & S3.last, register res_data = sat(dsp_p >>> OUT_SHIFT), set res_sat and res_valid.
  - res_valid clears on res_valid & res_ready unless a new capture happens in the same cycle.
- Latency: last sample accepted in cycle t → res_valid in cycle t+4 with no stalls. Sustained throughput is 1 tap/clock.
- Saturation: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; res_sat=1 iff clamped.
- Abort mid-command: in-flight tags and any pending result are discarded. The next command starts clean, because its first tag uses Z=C.

Decomposition:
- Shared package dsp48_pkg holds:
  - OPMODE constants OPM_MUL_C and OPM_MUL_ACC.
  - Slice width constants (A 30, B 18, P 48, MULT_A 25).
  - The tag struct {valid, first, last}.
- One sub-module, dsp48_sat_shift: combinational arithmetic shift plus saturation, reusable by other DSP wrappers.

Test Plan:
- OUT_SHIFT=0, cmd_len=3, a={1,2,3,4}, b={5,6,7,8}, res_ready=1 → res_data=70, res_sat=0, res_valid exactly 4 cycles after the 4th accept.
- Back-to-back: cmd_len=0 with a=-3,b=7, then immediately cmd_len=1 with a={2,2},b={10,-1} → results -21 then 18, no carry-over between sums.
- Bubbles: same 4-tap vector with in_valid toggling every other cycle → 70; dsp_cep is never high on a bubble.
- Backpressure: hold res_ready=0 for 10 cycles while the next command streams → in_ready=0 and all dsp_ce*=0 during the hold; both results correct once released.
- Round/sat: OUT_SHIFT=17, OUT_W=8, cmd_round=1:
  - One tap a=16777215, b=131071 → res_data=127, res_sat=1.
  - One tap a=3, b=21846 → P=65538+65536 → res_data=1.
- Abort: assert abort after 2 of 4 taps → no res_valid; the following 1-tap command a=5,b=5 → 25.

Source files
------------

// File: rtl/dsp48_pkg.sv
// Shared DSP48E1 definitions: slice port widths, OPMODE encodings, the
// pipeline tag that shadows data through the slice, and controller states.
package dsp48_pkg;

    localparam int A_W      = 30;
    localparam int B_W      = 18;
    localparam int P_W      = 48;
    localparam int MULT_A_W = 25;

    // X=M, Y=M, Z=C starts a new sum; X=M, Y=M, Z=P accumulates.
    localparam logic [6:0] OPM_MUL_C   = 7'b0110101;
    localparam logic [6:0] OPM_MUL_ACC = 7'b0100101;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

endpackage

// File: rtl/dsp48_sat_shift.sv
// Combinational arithmetic right shift of a slice P value followed by
// saturation into a narrower signed result.
module dsp48_sat_shift #(
    parameter int IN_W  = 48,
    parameter int OUT_W = 24,
    parameter int SHIFT = 17
) (
    input  logic [IN_W-1:0]  p_in,
    output logic [OUT_W-1:0] data,
    output logic             sat
);

    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

    logic signed [IN_W-1:0] shifted;

    always_comb begin
        shifted = $signed(p_in) >>> SHIFT;
        data    = shifted[OUT_W-1:0];
        sat     = 1'b0;
        if (shifted > MAX_V) begin
            data = MAX_V[OUT_W-1:0];
            sat  = 1'b1;
        end else if (shifted < MIN_V) begin
            data = MIN_V[OUT_W-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/dsp48_mac_sched.sv
// Sequences one DSP48E1 slice as an N-tap signed multiply-accumulate engine,
// with a tag pipeline that keeps control aligned with the slice registers.
module dsp48_mac_sched
    import dsp48_pkg::*;
#(
    parameter int LEN_W     = 10,
    parameter int OUT_W     = 24,
    parameter int OUT_SHIFT = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                abort,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic                cmd_round,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MULT_A_W-1:0] in_a,
    input  logic [B_W-1:0]      in_b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [OUT_W-1:0]    res_data,
    output logic                res_sat,
    output logic [A_W-1:0]      dsp_a,
    output logic [B_W-1:0]      dsp_b,
    output logic [P_W-1:0]      dsp_c,
    output logic [6:0]          dsp_opmode,
    output logic                dsp_cea2,
    output logic                dsp_ceb2,
    output logic                dsp_cem,
    output logic                dsp_cep,
    output logic                dsp_cectrl,
    output logic                dsp_rst,
    input  logic [P_W-1:0]      dsp_p
);

    // Half an output LSB; collapses to zero when no shift is applied.
    localparam logic [P_W-1:0] ROUND_K = {{(P_W-1){1'b0}}, 1'b1} << OUT_SHIFT >> 1;

    state_t           state;
    logic [LEN_W-1:0] cnt;
    logic             round_q;
    logic             first_q;
    logic             c_round;
    tag_t             s1, s2, s3;

    logic             flush, en, accept, cmd_fire, capture;
    logic [OUT_W-1:0] sat_data;
    logic             sat_flag;

    assign flush    = rst | abort;
    assign en       = !res_valid | res_ready;
    assign accept   = in_valid & in_ready;
    assign cmd_fire = cmd_valid & cmd_ready;
    assign capture  = en & s3.valid & s3.last;

    assign cmd_ready  = (state == ST_IDLE) & !flush;
    assign in_ready   = (state == ST_RUN) & en & !flush;

    assign dsp_a      = {{(A_W-MULT_A_W){in_a[MULT_A_W-1]}}, in_a};
    assign dsp_b      = in_b;
    assign dsp_c      = c_round ? ROUND_K : '0;
    assign dsp_cea2   = accept;
    assign dsp_ceb2   = accept;
    assign dsp_cem    = en & s1.valid & !flush;
    assign dsp_cep    = en & s2.valid & !flush;
    assign dsp_cectrl = en & !flush;
    assign dsp_rst    = flush;
    // OPMODE is registered in the slice alongside M, so it is decoded from S1.
    assign dsp_opmode = flush ? 7'd0 : (s1.first ? OPM_MUL_C : OPM_MUL_ACC);

    always_ff @(posedge clk) begin
        if (flush) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            round_q <= 1'b0;
            first_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        cnt     <= cmd_len;
                        round_q <= cmd_round;
                        first_q <= 1'b1;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        cnt     <= cnt - LEN_W'(1);
                        first_q <= 1'b0;
                        if (cnt == '0) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The rounding constant switches only when a new sum's first tag enters S1,
    // so tags of the previous sum still in flight never see it change under Z=C.
    always_ff @(posedge clk) begin
        if (flush) begin
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            c_round <= 1'b0;
        end else if (en) begin
            s1 <= '{valid: accept, first: accept & first_q, last: accept & (cnt == '0)};
            s2 <= s1;
            s3 <= s2;
            if (accept & first_q) begin
                c_round <= round_q;
            end
        end
    end

    dsp48_sat_shift #(
        .IN_W  (P_W),
        .OUT_W (OUT_W),
        .SHIFT (OUT_SHIFT)
    ) u_sat_shift (
        .p_in (dsp_p),
        .data (sat_data),
        .sat  (sat_flag)
    );

    always_ff @(posedge clk) begin
        if (flush) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_sat   <= 1'b0;
        end else if (capture) begin
            res_valid <= 1'b1;
            res_data  <= sat_data;
            res_sat   <= sat_flag;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule
